// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: core, loader and RAM buses meeting at the data-RAM arbiter
interface ram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req_i;
    logic [3:0]        core_wen_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [DATA_W-1:0] core_wdata_i;
    logic [DATA_W-1:0] core_rdata_o;
    logic              core_stall_o;
    logic              ld_req_i;
    logic [3:0]        ld_wen_i;
    logic [ADDR_W-1:0] ld_addr_i;
    logic [DATA_W-1:0] ld_wdata_i;
    logic              ld_ack_o;
    logic [DATA_W-1:0] ld_rdata_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [3:0]        ram_wen_o;
    logic [DATA_W-1:0] ram_rdata_i;
    modport slave (
        input  core_req_i, core_wen_i, core_addr_i, core_wdata_i,
        input  ld_req_i, ld_wen_i, ld_addr_i, ld_wdata_i, ram_rdata_i,
        output core_rdata_o, core_stall_o, ld_ack_o, ld_rdata_o,
        output ram_addr_o, ram_wdata_o, ram_wen_o
    );
    modport master (
        output core_req_i, core_wen_i, core_addr_i, core_wdata_i,
        output ld_req_i, ld_wen_i, ld_addr_i, ld_wdata_i, ram_rdata_i,
        input  core_rdata_o, core_stall_o, ld_ack_o, ld_rdata_o,
        input  ram_addr_o, ram_wdata_o, ram_wen_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the data-RAM port between the zero-latency core path and a latched loader
module ram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic          clk_i,
    input logic          rst_i,
    ram_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    typedef enum logic [1:0] {IDLE, LD_PEND, LD_RESP} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0] ld_wdata_q, ld_wdata_d;
    logic [3:0]        ld_wen_q, ld_wen_d;
    logic              ld_ack_q, ld_ack_d;
    logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
    logic              issue, accept;
    always_comb begin
        issue      = state_q == LD_PEND && (!bus.core_req_i || wait_cnt_q == CW'(MAX_WAIT));
        accept     = state_q == IDLE && bus.ld_req_i && !ld_ack_q;
        state_d    = accept ? LD_PEND : issue ? LD_RESP : state_q == LD_RESP ? IDLE : state_q;
        wait_cnt_d = accept ? '0 : (state_q == LD_PEND && !issue) ? wait_cnt_q + CW'(1) : wait_cnt_q;
        ld_addr_d  = accept ? bus.ld_addr_i : ld_addr_q;
        ld_wdata_d = accept ? bus.ld_wdata_i : ld_wdata_q;
        ld_wen_d   = accept ? bus.ld_wen_i : ld_wen_q;
        ld_ack_d   = state_q == LD_RESP;
        ld_rdata_d = ld_ack_d ? bus.ram_rdata_i : ld_rdata_q;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            ld_addr_q  <= '0;
            ld_wdata_q <= '0;
            ld_wen_q   <= '0;
            ld_ack_q   <= 1'b0;
            ld_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ld_addr_q  <= ld_addr_d;
            ld_wdata_q <= ld_wdata_d;
            ld_wen_q   <= ld_wen_d;
            ld_ack_q   <= ld_ack_d;
            ld_rdata_q <= ld_rdata_d;
        end
    end
    // the loader owns the port only in its issue cycle; the core wins every other cycle
    assign bus.ram_addr_o   = issue ? ld_addr_q : bus.core_addr_i;
    assign bus.ram_wdata_o  = issue ? ld_wdata_q : bus.core_wdata_i;
    assign bus.ram_wen_o    = issue ? ld_wen_q : bus.core_req_i ? bus.core_wen_i : 4'h0;
    assign bus.core_stall_o = issue && bus.core_req_i;
    assign bus.core_rdata_o = bus.ram_rdata_i;
    assign bus.ld_ack_o     = ld_ack_q;
    assign bus.ld_rdata_o   = ld_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random traffic against a transaction-level model of the arbiter
module tb_ram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    int n_checks = 0;
    int n_fail = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // read-first synchronous RAM with byte enables
    logic [31:0] mem [64] = '{default: '0};
    always @(posedge clk) begin
        bus.ram_rdata_i <= mem[bus.ram_addr_o[7:2]];
        for (int b = 0; b < 4; b++)
            if (bus.ram_wen_o[b]) mem[bus.ram_addr_o[7:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
    end
    // reference: a pending loader transaction yields MW times to a busy core, then forces one slot
    logic [31:0] ref_mem [64] = '{default: '0};
    bit pend, resp, ack_now, prev_rd, model_en, drv_stall, drv_ack, iss, stl, acc;
    int yields;
    logic [31:0] la, ld_d, iss_data, ack_data, rd_exp, ea, wd, word;
    logic [3:0] lwen, ew;
    always @(negedge clk) begin
        drv_stall = bus.core_stall_o;
        drv_ack = bus.ld_ack_o;
        if (!model_en) begin
            pend = 0; resp = 0; ack_now = 0; prev_rd = 0; yields = 0;
        end else begin
            iss  = pend && (!bus.core_req_i || yields == MW);
            stl  = iss && bus.core_req_i;
            ea   = iss ? la : bus.core_addr_i;
            ew   = iss ? lwen : bus.core_req_i ? bus.core_wen_i : 4'h0;
            wd   = iss ? ld_d : bus.core_wdata_i;
            word = ref_mem[ea[7:2]];
            check("stall", bus.core_stall_o, stl);
            check("ram_addr", bus.ram_addr_o, ea);
            check("ram_wen", bus.ram_wen_o, ew);
            if (ew != 0) check("ram_wdata", bus.ram_wdata_o, wd);
            check("ld_ack", bus.ld_ack_o, ack_now);
            if (ack_now) check("ld_rdata", bus.ld_rdata_o, ack_data);
            if (prev_rd) check("core_rdata", bus.core_rdata_o, rd_exp);
            for (int b = 0; b < 4; b++)
                if (ew[b]) ref_mem[ea[7:2]][8*b +: 8] = wd[8*b +: 8];
            prev_rd = bus.core_req_i && !stl && bus.core_wen_i == 4'h0;
            rd_exp  = word;
            acc     = !pend && !resp && !ack_now && bus.ld_req_i;
            ack_now = resp;
            if (resp) ack_data = iss_data;
            resp = iss;
            if (iss) iss_data = word;
            yields = acc ? 0 : (pend && !iss) ? yields + 1 : yields;
            pend   = acc || (pend && !iss);
            if (acc) begin
                la = bus.ld_addr_i; ld_d = bus.ld_wdata_i; lwen = bus.ld_wen_i;
            end
        end
    end
    initial begin
        bus.core_req_i = 0; bus.core_wen_i = 0; bus.core_addr_i = 0; bus.core_wdata_i = 0;
        bus.ld_req_i = 0; bus.ld_wen_i = 0; bus.ld_addr_i = 0; bus.ld_wdata_i = 0;
        model_en = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", bus.core_stall_o, 0);
        check("rst_ack", bus.ld_ack_o, 0);
        check("rst_rdata", bus.ld_rdata_o, 0);
        rst = 0;
        model_en = 1;
        step();
        bus.ld_req_i = 1; bus.ld_addr_i = 32'h10; bus.ld_wen_i = 4'hF; bus.ld_wdata_i = 32'hDEADBEEF;
        step();
        check("wr_addr", bus.ram_addr_o, 32'h10);
        check("wr_wen", bus.ram_wen_o, 4'hF);
        step();
        check("wr_ack_n2", bus.ld_ack_o, 0);
        step();
        check("wr_ack_n3", bus.ld_ack_o, 1);
        bus.ld_req_i = 0;
        step();
        check("wr_ack_n4", bus.ld_ack_o, 0);
        bus.ld_req_i = 1; bus.ld_wen_i = 4'h0;
        for (int i = 0; i < 6 && !bus.ld_ack_o; i++) step();
        check("rb_ack", bus.ld_ack_o, 1);
        check("rb_data", bus.ld_rdata_o, 32'hDEADBEEF);
        bus.ld_req_i = 0;
        step();
        bus.core_req_i = 1; bus.core_addr_i = 32'h20; bus.core_wen_i = 4'b0011; bus.core_wdata_i = 32'hAABBCCDD;
        #1;
        check("cw_wen", bus.ram_wen_o, 4'b0011);
        check("cw_stall", bus.core_stall_o, 0);
        step();
        bus.core_wen_i = 4'h0;
        step();
        check("cw_merged", bus.core_rdata_o, 32'h0000CCDD);
        bus.core_addr_i = 32'h40;
        bus.ld_req_i = 1; bus.ld_addr_i = 32'h10; bus.ld_wen_i = 4'h0;
        step();
        for (int k = 1; k <= 5; k++) begin
            check("sv_stall", bus.core_stall_o, k == 5);
            check("sv_owner", bus.ram_addr_o, k == 5 ? 32'h10 : 32'h40);
            step();
        end
        check("sv_stall6", bus.core_stall_o, 0);
        check("sv_ack6", bus.ld_ack_o, 0);
        step();
        check("sv_ack7", bus.ld_ack_o, 1);
        check("sv_data", bus.ld_rdata_o, 32'hDEADBEEF);
        bus.ld_req_i = 0; bus.core_req_i = 0;
        step();
        bus.ld_req_i = 1; bus.ld_addr_i = 32'h30; bus.ld_wen_i = 4'hF; bus.ld_wdata_i = 32'h12345678;
        for (int i = 0; i < 6 && !bus.ld_ack_o; i++) step();
        check("hr_ack1", bus.ld_ack_o, 1);
        check("hr_noissue", bus.ram_wen_o, 4'h0);
        step();
        check("hr_idle_ack", bus.ld_ack_o, 0);
        check("hr_idle_wen", bus.ram_wen_o, 4'h0);
        step();
        check("hr_issue", bus.ram_wen_o, 4'hF);
        step();
        check("hr_resp", bus.ld_ack_o, 0);
        step();
        check("hr_ack2", bus.ld_ack_o, 1);
        bus.ld_req_i = 0;
        step();
        bus.core_req_i = 1; bus.core_addr_i = 32'h40; bus.core_wen_i = 4'h0;
        bus.ld_req_i = 1; bus.ld_addr_i = 32'h10; bus.ld_wen_i = 4'hF; bus.ld_wdata_i = 32'h0;
        step();
        step();
        #2;
        model_en = 0;
        rst = 1;
        #1;
        check("mr_stall", bus.core_stall_o, 0);
        check("mr_ack", bus.ld_ack_o, 0);
        check("mr_rdata", bus.ld_rdata_o, 0);
        check("mr_addr", bus.ram_addr_o, 32'h40);
        check("mr_wen", bus.ram_wen_o, 4'h0);
        bus.ld_req_i = 0; bus.core_req_i = 0;
        step();
        rst = 0;
        model_en = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("mr_noack", bus.ld_ack_o, 0);
        end
        for (int i = 0; i < 600; i++) begin
            if (!drv_stall) begin
                bus.core_req_i   = $urandom_range(0, 9) < 7;
                bus.core_wen_i   = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
                bus.core_addr_i  = 32'($urandom_range(0, 15)) << 2;
                bus.core_wdata_i = $urandom;
            end
            if (!bus.ld_req_i || drv_ack) begin
                bus.ld_req_i   = $urandom_range(0, 1);
                bus.ld_wen_i   = $urandom_range(0, 1) == 0 ? 4'($urandom) : 4'h0;
                bus.ld_addr_i  = 32'($urandom_range(0, 15)) << 2;
                bus.ld_wdata_i = $urandom;
            end
            step();
        end
        bus.core_req_i = 0; bus.ld_req_i = 0;
        repeat (8) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
